// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply job sequencer.
// The descriptor is packed as {base, res, tag}.
package mm_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int TAG_W_DEF   = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    REPORT
  } state_e;

  localparam logic [1:0] STS_OK      = 2'b00;
  localparam logic [1:0] STS_TIMEOUT = 2'b01;
  localparam logic [1:0] STS_ABORT   = 2'b10;

  function automatic int desc_w(input int aw, input int tw);
    return 2 * aw + tw;
  endfunction

endpackage

// File: rtl/mm_job_fifo.sv
// Descriptor queue for the job sequencer.
// Flush beats push and pop, and a full queue never accepts a push.
module mm_job_fifo
  import mm_pkg::*;
#(
  parameter int W     = 36,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + AW'(do_push);
      rd_d  = rd_q + AW'(do_pop);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/mm_job_sequencer.sv
// Launch controller: queues job descriptors, starts the accelerator
// one job at a time and returns a status record per finished job.
module mm_job_sequencer
  import mm_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_base_addr,
  input  logic [ADDR_W-1:0] job_res_addr,
  input  logic [TAG_W-1:0]  job_tag,
  output logic              acc_comp_enb,
  output logic [ADDR_W-1:0] acc_base_addr,
  output logic [ADDR_W-1:0] acc_res_addr,
  input  logic              acc_busyb,
  input  logic              acc_done,
  input  logic              abort,
  output logic              sts_valid,
  input  logic              sts_ready,
  output logic [TAG_W-1:0]  sts_tag,
  output logic [1:0]        sts_code,
  output logic [CNT_W-1:0]  sts_cycles,
  output logic              idle
);

  localparam int DW = desc_w(ADDR_W, TAG_W);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0]     f_din, f_dout;
  logic              f_push, f_pop;
  logic              f_full, f_empty;
  logic [CW-1:0]     f_count;
  logic [ADDR_W-1:0] q_base, q_res;
  logic [TAG_W-1:0]  q_tag;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] res_q, res_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic [TAG_W-1:0]  sts_tag_q, sts_tag_d;
  logic [1:0]        sts_code_q, sts_code_d;
  logic [CNT_W-1:0]  sts_cyc_q, sts_cyc_d;
  logic              timeout;

  assign f_din  = {job_base_addr, job_res_addr, job_tag};
  assign {q_base, q_res, q_tag} = f_dout;
  assign f_push = job_valid & ~f_full & ~abort;

  mm_job_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .pop   (f_pop),
    .flush (abort),
    .din   (f_din),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // cnt reads 1 in the launch cycle, so it counts launch..end inclusive
  assign cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    res_d      = res_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    sts_tag_d  = sts_tag_q;
    sts_code_d = sts_code_q;
    sts_cyc_d  = sts_cyc_q;
    f_pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!f_empty && acc_busyb && !abort) begin
          f_pop   = 1'b1;
          base_d  = q_base;
          res_d   = q_res;
          tag_d   = q_tag;
          cnt_d   = CNT_W'(1);
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = cnt_nxt;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_nxt;
        if (acc_done || timeout || abort) begin
          sts_tag_d = tag_q;
          sts_cyc_d = cnt_q;
          state_d   = REPORT;
          if (acc_done)     sts_code_d = STS_OK;
          else if (timeout) sts_code_d = STS_TIMEOUT;
          else              sts_code_d = STS_ABORT;
        end
      end
      REPORT: begin
        if (sts_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      res_q      <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      sts_tag_q  <= '0;
      sts_code_q <= '0;
      sts_cyc_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      res_q      <= res_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      sts_tag_q  <= sts_tag_d;
      sts_code_q <= sts_code_d;
      sts_cyc_q  <= sts_cyc_d;
    end
  end

  assign job_ready     = ~f_full;
  assign acc_comp_enb  = (state_q == LAUNCH);
  assign acc_base_addr = base_q;
  assign acc_res_addr  = res_q;
  assign sts_valid     = (state_q == REPORT);
  assign sts_tag       = sts_tag_q;
  assign sts_code      = sts_code_q;
  assign sts_cycles    = sts_cyc_q;
  assign idle          = (state_q == IDLE) && (f_count == '0);

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Scoreboard bench for mm_job_sequencer: an accelerator model decides
// how each launched job ends and queues the status it must produce.
module tb_mm_job_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 1024;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        job_valid = 0;
  logic        job_ready;
  logic [15:0] job_base_addr = 0;
  logic [15:0] job_res_addr = 0;
  logic [3:0]  job_tag = 0;
  logic        acc_comp_enb;
  logic [15:0] acc_base_addr;
  logic [15:0] acc_res_addr;
  logic        acc_busyb = 1;
  logic        acc_done = 0;
  logic        abort = 0;
  logic        sts_valid;
  logic        sts_ready = 1;
  logic [3:0]  sts_tag;
  logic [1:0]  sts_code;
  logic [15:0] sts_cycles;
  logic        idle;

  mm_job_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_base_addr (job_base_addr),
    .job_res_addr  (job_res_addr),
    .job_tag       (job_tag),
    .acc_comp_enb  (acc_comp_enb),
    .acc_base_addr (acc_base_addr),
    .acc_res_addr  (acc_res_addr),
    .acc_busyb     (acc_busyb),
    .acc_done      (acc_done),
    .abort         (abort),
    .sts_valid     (sts_valid),
    .sts_ready     (sts_ready),
    .sts_tag       (sts_tag),
    .sts_code      (sts_code),
    .sts_cycles    (sts_cycles),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [15:0] base;
    logic [15:0] res;
    logic [3:0]  tag;
  } job_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [1:0]  code;
    logic [15:0] cycles;
  } sts_t;

  job_t launch_q[$];
  sts_t sts_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int done_k_cfg = 5;
  int abort_k_cfg = -1;
  bit kill = 0;
  bit resp_busy = 0;
  bit rand_ready = 0;
  int n_launch = 0;
  int launch_cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Accelerator model: on each start it picks done/abort cycles and
  // derives the outcome from the priority done > timeout > abort.
  always begin
    job_t j;
    int dk, ak, term;
    logic [1:0] code;
    @(negedge clk);
    if (rst_n && acc_comp_enb) begin
      resp_busy = 1;
      n_launch++;
      launch_cyc = cyc;
      chk("launch_busyb", acc_busyb, 1);
      if (launch_q.size() == 0) begin
        chk("unexpected_launch", 1, 0);
        j = '0;
      end else begin
        j = launch_q.pop_front();
        chk("acc_base", acc_base_addr, j.base);
        chk("acc_res", acc_res_addr, j.res);
      end
      dk = done_k_cfg;
      ak = abort_k_cfg;
      if (dk == -2) dk = $urandom_range(1, 40);
      term = TIMEOUT - 1;
      if (ak >= 1 && ak < term) term = ak;
      if (dk >= 1 && dk <= term) term = dk;
      if (dk == term) code = 2'b00;
      else if (term == TIMEOUT - 1) code = 2'b01;
      else code = 2'b10;
      for (int i = 1; i <= term; i++) begin
        @(posedge clk);
        #1;
        if (kill) break;
        acc_done = (i == dk);
        abort    = (i == ak);
      end
      @(posedge clk);
      #1;
      acc_done = 0;
      abort = 0;
      if (!kill) begin
        sts_q.push_back('{tag: j.tag, code: code, cycles: 16'(term + 1)});
        if (code == 2'b10) launch_q.delete();
      end
      resp_busy = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    sts_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    sts_t e;
    if (rst_n && sts_valid && sts_ready) begin
      if (sts_q.size() == 0) begin
        chk("unexpected_status", sts_tag, 16'hffff);
      end else begin
        e = sts_q.pop_front();
        chk("sts_tag", sts_tag, e.tag);
        chk("sts_code", sts_code, e.code);
        chk("sts_cycles", sts_cycles, e.cycles);
      end
    end
  end

  task automatic push_job(input job_t j, output int pc);
    int n = 0;
    job_base_addr = j.base;
    job_res_addr = j.res;
    job_tag = j.tag;
    job_valid = 1;
    @(negedge clk);
    while (!job_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", job_ready, 1);
    pc = cyc;
    if (job_ready) launch_q.push_back(j);
    @(posedge clk);
    #1;
    job_valid = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sts_q.size() == 0 && launch_q.size() == 0 &&
          !resp_busy && idle) begin
        ok = 1;
        break;
      end
    end
    chk("drain", ok, 1);
    step(1);
  endtask

  task automatic wait_launch(input int n0);
    int n = 0;
    while (n_launch == n0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("launch_seen", n_launch > n0, 1);
  endtask

  task automatic chk_reset_vals();
    @(negedge clk);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_comp_enb", acc_comp_enb, 0);
    chk("rst_sts_valid", sts_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_acc_base", acc_base_addr, 0);
    chk("rst_acc_res", acc_res_addr, 0);
    chk("rst_sts_tag", sts_tag, 0);
    chk("rst_sts_code", sts_code, 0);
    chk("rst_sts_cycles", sts_cycles, 0);
    step(1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, n0;
    job_t j;
    rst_n = 0;
    step(3);
    chk_reset_vals();
    rst_n = 1;
    step(1);
    chk_reset_vals();

    // single job, latency and cycle count
    done_k_cfg = 5;
    n0 = n_launch;
    push_job('{base: 16'h0000, res: 16'h0100, tag: 4'd3}, pc);
    wait_launch(n0);
    chk("launch_latency", launch_cyc - pc, 2);
    wait_drain();

    // queue fill with the accelerator stalled
    acc_busyb = 0;
    done_k_cfg = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ready_before_push", job_ready, launch_q.size() < DEPTH);
      step(0);
      @(posedge clk);
      #1;
      push_job('{base: 16'(16'h1000 + i), res: 16'(16'h2000 + i),
                 tag: 4'(i + 4)}, pc);
    end
    job_base_addr = 16'h1004;
    job_res_addr = 16'h2004;
    job_tag = 4'd8;
    job_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", job_ready, launch_q.size() < DEPTH);
      chk("full_not_idle", idle, 0);
      step(1);
    end
    acc_busyb = 1;
    push_job('{base: 16'h1004, res: 16'h2004, tag: 4'd8}, pc);
    wait_drain();

    // timeout, then the next job still launches
    done_k_cfg = -1;
    n0 = n_launch;
    push_job('{base: 16'h3000, res: 16'h3100, tag: 4'd1}, pc);
    push_job('{base: 16'h3200, res: 16'h3300, tag: 4'd2}, pc);
    wait_launch(n0);
    done_k_cfg = 4;
    wait_drain();
    chk("timeout_next_launch", n_launch - n0, 2);

    // abort in RUN with two jobs queued
    done_k_cfg = -1;
    abort_k_cfg = 3;
    n0 = n_launch;
    for (int i = 0; i < 3; i++)
      push_job('{base: 16'(16'h4000 + i), res: 16'(16'h5000 + i),
                 tag: 4'(i + 9)}, pc);
    wait_drain();
    step(10);
    @(negedge clk);
    chk("abort_launches", n_launch - n0, 1);
    chk("abort_idle", idle, 1);
    step(1);

    // done together with abort, done at the timeout cycle, abort at it
    done_k_cfg = 4;
    abort_k_cfg = 4;
    push_job('{base: 16'h6000, res: 16'h6100, tag: 4'd12}, pc);
    wait_drain();
    done_k_cfg = TIMEOUT - 1;
    abort_k_cfg = -1;
    push_job('{base: 16'h6200, res: 16'h6300, tag: 4'd13}, pc);
    wait_drain();
    done_k_cfg = -1;
    abort_k_cfg = TIMEOUT - 1;
    push_job('{base: 16'h6400, res: 16'h6500, tag: 4'd14}, pc);
    wait_drain();
    abort_k_cfg = -1;

    // accelerator busy holds off the launch
    acc_busyb = 0;
    done_k_cfg = 2;
    n0 = n_launch;
    push_job('{base: 16'h7000, res: 16'h7100, tag: 4'd15}, pc);
    step(10);
    @(negedge clk);
    chk("busy_no_launch", n_launch, n0);
    chk("busy_not_idle", idle, 0);
    step(1);
    acc_busyb = 1;
    wait_drain();
    chk("busy_then_launch", n_launch - n0, 1);

    // randomized jobs with random latency and consumer back-pressure
    rand_ready = 1;
    done_k_cfg = -2;
    for (int i = 0; i < 20; i++) begin
      j.base = 16'($urandom);
      j.res = 16'($urandom);
      j.tag = 4'($urandom);
      push_job(j, pc);
      step($urandom_range(0, 3));
    end
    wait_drain();
    rand_ready = 0;

    // reset while a job runs: no status, outputs back to reset values
    done_k_cfg = -1;
    n0 = n_launch;
    push_job('{base: 16'h8000, res: 16'h8100, tag: 4'd6}, pc);
    wait_launch(n0);
    step(5);
    kill = 1;
    rst_n = 0;
    step(2);
    chk_reset_vals();
    rst_n = 1;
    step(3);
    kill = 0;
    chk_reset_vals();
    step(20);
    @(negedge clk);
    chk("post_reset_no_sts", sts_valid, 0);
    chk("post_reset_idle", idle, 1);
    chk("post_reset_no_exp", sts_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
